// File: rtl/e203_ifu_flush_pkg.sv
// Shared types and constants for the IFU flush/halt fetch controller.
// Optional registered flush target: E203_FLUSH_TGT_REG_EN.
package e203_ifu_flush_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_HALT_DRAIN = 2'd1,
    ST_HALTED     = 2'd2
  } ifu_state_e;

  localparam int unsigned FETCH_INC = 4;

  function automatic int unsigned outs_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/e203_ifu_outs_cnt.sv
// Saturating up/down counter with parallel load.
// Used for the outstanding-request count and the kill count.
module e203_ifu_outs_cnt
  import e203_ifu_flush_pkg::*;
#(
  parameter int unsigned MAX = 2,
  parameter int unsigned W   = outs_cnt_w(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && !dec_i && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/e203_ifu_flush_ctrl.sv
// IFU fetch request generator answering commit flush and WFI halt requests.
// Define E203_FLUSH_TGT_REG_EN to register the flush target (ack one cycle late).
module e203_ifu_flush_ctrl
  import e203_ifu_flush_pkg::*;
#(
  parameter int unsigned         PC_SIZE    = 32,
  parameter logic [PC_SIZE-1:0]  RESET_PC   = PC_SIZE'(32'h0000_1000),
  parameter int unsigned         OUTS_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_req,
  input  logic [PC_SIZE-1:0] flush_add_op1,
  input  logic [PC_SIZE-1:0] flush_add_op2,
  output logic               flush_ack,
  input  logic               halt_req,
  output logic               halt_ack,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  output logic [PC_SIZE-1:0] ifu_req_pc,
  input  logic               ifu_rsp_valid,
  output logic               ifu_rsp_ready,
  output logic               ifu_rsp_kill,
  output logic               ifu_halted
);

  localparam int unsigned   CW      = outs_cnt_w(OUTS_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(OUTS_DEPTH);

  ifu_state_e state_q;
  ifu_state_e state_d;

  logic [PC_SIZE-1:0] pc_q;
  logic [PC_SIZE-1:0] pc_d;
  logic [PC_SIZE-1:0] tgt;

  logic [CW-1:0] outs_cnt;
  logic [CW-1:0] kill_cnt;
  logic [CW-1:0] kill_ld;

  logic req_hsk;
  logic rsp_hsk;
  logic flush_acc;
  logic drain_ok;

`ifdef E203_FLUSH_TGT_REG_EN
  logic               pend_q;
  logic               pend_d;
  logic [PC_SIZE-1:0] tgt_q;
  logic [PC_SIZE-1:0] tgt_d;

  // First sighting of flush_req captures the sum; the next cycle acks.
  always_comb begin
    pend_d = flush_req & ~pend_q;
    tgt_d  = tgt_q;
    if (pend_d) begin
      tgt_d = flush_add_op1 + flush_add_op2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      tgt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      tgt_q  <= tgt_d;
    end
  end

  assign flush_acc = flush_req & pend_q;
  assign tgt       = tgt_q;
`else
  assign flush_acc = flush_req & ~rst;
  assign tgt       = flush_add_op1 + flush_add_op2;
`endif

  assign ifu_req_valid = ~rst
                       & (state_q == ST_RUN)
                       & ~halt_req
                       & ~flush_req
                       & (outs_cnt < DEPTH_C);

  assign req_hsk = ifu_req_valid & ifu_req_ready;
  // A response with nothing outstanding is ignored.
  assign rsp_hsk = ifu_rsp_valid & (outs_cnt != '0);
  assign kill_ld = outs_cnt - CW'(rsp_hsk);

  assign drain_ok = (outs_cnt == '0)
                  | ((outs_cnt == CW'(1)) & rsp_hsk);

  e203_ifu_outs_cnt #(
    .MAX (OUTS_DEPTH),
    .W   (CW)
  ) u_outs_cnt (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (req_hsk),
    .dec_i      (rsp_hsk),
    .load_i     (1'b0),
    .load_val_i ('0),
    .cnt_o      (outs_cnt)
  );

  e203_ifu_outs_cnt #(
    .MAX (OUTS_DEPTH),
    .W   (CW)
  ) u_kill_cnt (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (1'b0),
    .dec_i      (rsp_hsk),
    .load_i     (flush_acc),
    .load_val_i (kill_ld),
    .cnt_o      (kill_cnt)
  );

  always_comb begin
    pc_d = pc_q;
    if (flush_acc) begin
      pc_d = tgt;
    end else if (req_hsk) begin
      pc_d = pc_q + PC_SIZE'(FETCH_INC);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d = (flush_acc && drain_ok) ? ST_HALTED : ST_HALT_DRAIN;
        end
      end
      ST_HALT_DRAIN: begin
        if (!halt_req) begin
          state_d = ST_RUN;
        end else if (drain_ok) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (!halt_req) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign flush_ack     = flush_acc;
  assign ifu_req_pc    = pc_q;
  assign ifu_rsp_ready = 1'b1;
  assign ifu_rsp_kill  = flush_acc | (kill_cnt != '0);
  assign ifu_halted    = (state_q == ST_HALTED);
  assign halt_ack      = (state_q == ST_HALTED) & halt_req;

endmodule

// File: tb/tb_e203_ifu_flush_ctrl.sv
// Directed + random bench for e203_ifu_flush_ctrl against a queue-based model.
`timescale 1ns/1ps
module tb_e203_ifu_flush_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam int          DEPTH  = 2;
`ifdef E203_FLUSH_TGT_REG_EN
  localparam int          ACK_LAT = 1;
`else
  localparam int          ACK_LAT = 0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush_req;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        flush_ack;
  logic        halt_req;
  logic        halt_ack;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_pc;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready;
  logic        ifu_rsp_kill;
  logic        ifu_halted;

  e203_ifu_flush_ctrl #(
    .PC_SIZE    (32),
    .RESET_PC   (RST_PC),
    .OUTS_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_req     (flush_req),
    .flush_add_op1 (op1),
    .flush_add_op2 (op2),
    .flush_ack     (flush_ack),
    .halt_req      (halt_req),
    .halt_ack      (halt_ack),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_req_pc    (ifu_req_pc),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_ready (ifu_rsp_ready),
    .ifu_rsp_kill  (ifu_rsp_kill),
    .ifu_halted    (ifu_halted)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: outstanding requests as a FIFO of "stale" flags.
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  bit          m_pend;
  bit          m_q[$];
  int          m_st;

  bit          e_ack;
  bit          e_valid;
  bit          e_kill;
  logic        o_ack   = 1'b0;
  logic        o_valid = 1'b0;
  logic        o_kill  = 1'b0;
  logic        o_hack  = 1'b0;
  logic        o_halt  = 1'b0;
  logic [31:0] o_pc    = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    bit stale;
    bit hsk;
    bit rsp;
    bit dok;
    int n;
    #3;
    if (rst) begin
      m_pc   = RST_PC;
      m_tgt  = '0;
      m_pend = 1'b0;
      m_st   = 0;
      m_q.delete();
    end
    stale = 1'b0;
    foreach (m_q[i]) if (m_q[i]) stale = 1'b1;
    e_ack   = !rst && flush_req && (ACK_LAT == 0 || m_pend);
    e_valid = !rst && m_st == 0 && !halt_req && !flush_req
              && m_q.size() < DEPTH;
    e_kill  = e_ack || stale;
    chk("valid", ifu_req_valid, e_valid);
    chk("pc", ifu_req_pc, m_pc);
    chk("flush_ack", flush_ack, e_ack);
    chk("kill", ifu_rsp_kill, e_kill);
    chk("halted", ifu_halted, m_st == 2);
    chk("halt_ack", halt_ack, m_st == 2 && halt_req);
    chk("rsp_ready", ifu_rsp_ready, 1);
    o_ack   = flush_ack;
    o_valid = ifu_req_valid;
    o_kill  = ifu_rsp_kill;
    o_hack  = halt_ack;
    o_halt  = ifu_halted;
    o_pc    = ifu_req_pc;
    @(posedge clk);
    if (!rst) begin
      n   = m_q.size();
      hsk = e_valid && ifu_req_ready;
      rsp = ifu_rsp_valid && n > 0;
      dok = (n == 0) || (n == 1 && rsp);
      if (rsp) void'(m_q.pop_front());
      if (hsk) m_q.push_back(1'b0);
      if (e_ack) begin
        foreach (m_q[i]) m_q[i] = 1'b1;
        m_pc = (ACK_LAT != 0) ? m_tgt : op1 + op2;
      end else if (hsk) begin
        m_pc = m_pc + 32'd4;
      end
      if (flush_req && !m_pend) m_tgt = op1 + op2;
      m_pend = flush_req && !m_pend;
      case (m_st)
        0: if (halt_req) m_st = (e_ack && dok) ? 2 : 1;
        1: if (!halt_req) m_st = 0; else if (dok) m_st = 2;
        default: if (!halt_req) m_st = 0;
      endcase
    end
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    flush_req     = 1'b0;
    halt_req      = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_req_ready = 1'b1;
    op1           = '0;
    op2           = '0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic do_flush(input logic [31:0] a, input logic [31:0] b);
    int k;
    flush_req = 1'b1;
    op1       = a;
    op2       = b;
    for (k = 0; k < 4; k++) begin
      cyc();
      if (o_ack === 1'b1) break;
    end
    chk("flush_lat", k, ACK_LAT);
    chk("flush_kill", o_kill, 1);
    flush_req = 1'b0;
    op1       = $urandom;
    op2       = $urandom;
  endtask

  initial begin
    logic [31:0] got[$];
    bool_init();
    rst = 1'b1;
    flush_req = 1'b0;
    halt_req = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_req_ready = 1'b1;
    op1 = '0;
    op2 = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Sequential fetch with 1-cycle responses
    for (int k = 0; k < 3; k++) begin
      ifu_rsp_valid = (m_q.size() != 0);
      cyc();
      chk("t1_valid", o_valid, 1);
      chk("t1_pc", o_pc, RST_PC + 32'(4 * k));
    end

    // Responses withheld: only DEPTH requests
    do_reset();
    ifu_rsp_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t2_valid", o_valid, (k < 2) ? 1 : 0);
    end

    // Flush with two outstanding
    do_flush(32'h8000_0000, 32'h0000_0040);
    ifu_rsp_valid = 1'b1;
    cyc();
    chk("t3_killA", o_kill, 1);
    chk("t3_pc", o_pc, 32'h8000_0040);
    cyc();
    chk("t3_killB", o_kill, 1);
    chk("t3_validB", o_valid, 1);
    cyc();
    chk("t3_killC", o_kill, 0);
    ifu_rsp_valid = 1'b0;

    // Halt with one outstanding
    do_reset();
    cyc();
    halt_req = 1'b1;
    cyc();
    chk("t4_valid_off", o_valid, 0);
    cyc();
    ifu_rsp_valid = 1'b1;
    cyc();
    chk("t4_ack_early", o_hack, 0);
    ifu_rsp_valid = 1'b0;
    cyc();
    chk("t4_ack", o_hack, 1);
    halt_req = 1'b0;
    cyc();
    chk("t4_still_halted", o_halt, 1);
    cyc();
    chk("t4_resume_v", o_valid, 1);
    chk("t4_resume_pc", o_pc, 32'h0000_1004);

    // Flush while halted
    halt_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ifu_rsp_valid = (m_q.size() != 0);
      cyc();
    end
    ifu_rsp_valid = 1'b0;
    chk("t5_halted", o_halt, 1);
    do_flush(32'h0000_0800, 32'h0);
    cyc();
    chk("t5_still_halted", o_halt, 1);
    chk("t5_hack", o_hack, 1);
    halt_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (o_valid === 1'b1) break;
    end
    chk("t5_valid", o_valid, 1);
    chk("t5_pc", o_pc, 32'h0000_0800);

    // Wrapping flush target
    do_flush(32'hFFFF_FFFC, 32'h0000_0008);
    for (int k = 0; k < 8; k++) begin
      ifu_rsp_valid = (m_q.size() != 0);
      cyc();
      if (o_valid === 1'b1 && ifu_req_ready) got.push_back(o_pc);
    end
    chk("t6_count", got.size() >= 2, 1);
    if (got.size() >= 2) begin
      chk("t6_pc0", got[0], 32'h0000_0004);
      chk("t6_pc1", got[1], 32'h0000_0008);
    end

    // Random traffic with a mid-run reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = (i == 1500 || i == 1501);
      ifu_req_ready = ($urandom_range(3) != 0);
      if (m_q.size() != 0) ifu_rsp_valid = ($urandom_range(1) == 1);
      else ifu_rsp_valid = ($urandom_range(15) == 0);
      if ($urandom_range(19) == 0) halt_req = ~halt_req;
      if (!(flush_req && o_ack !== 1'b1)) begin
        flush_req = ($urandom_range(11) == 0);
        op1 = $urandom;
        op2 = $urandom;
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic bool_init();
    m_pc   = RST_PC;
    m_tgt  = '0;
    m_pend = 1'b0;
    m_st   = 0;
    m_q.delete();
  endtask

endmodule
